// File: rtl/lpdaq_pkg.sv
// Shared types and helpers for the low-power DAQ acquisition path.
// Holds the acquisition FSM encoding and the register-width sign extension.
package lpdaq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RST    = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } acq_state_e;

    localparam int ADS_DATA_W = 24;
    localparam int REG_W      = 32;

    // Replicates bit w-1 of v into all bits above it.
    function automatic logic [REG_W-1:0] sign_extend(input logic [REG_W-1:0] v, input int w);
        logic signed [REG_W-1:0] t;
        t = $signed(v << (REG_W - w));
        return t >>> (REG_W - w);
    endfunction

endpackage

// File: rtl/ads127l01_frame_rx.sv
// ADS127L01 frame-sync receiver: synchronises sck/dout/fsync, detects rising edges,
// shifts DATA_W bits MSB first after each fsync and flags frames cut short by a new fsync.
module ads127l01_frame_rx
    import lpdaq_pkg::*;
#(
    parameter int DATA_W      = ADS_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              capture_en,
    input  logic              sck,
    input  logic              dout,
    input  logic              fsync,
    output logic              frame_valid,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_trunc,
    output logic              fsync_rise
);

    localparam int BITCNT_W = $clog2(DATA_W + 1);

    // Bit order in each stage: {fsync, dout, sck}
    logic [2:0]          sync_reg [SYNC_STAGES];
    logic [2:0]          prev_reg;
    logic [2:0]          sync_q;
    logic [2:0]          rise;
    logic [DATA_W-1:0]   shift_reg;
    logic [BITCNT_W-1:0] bitcnt_reg;
    logic                armed_reg;
    logic                sck_rise;
    logic                dout_s;
    logic                last_bit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            prev_reg <= '0;
        end else begin
            sync_reg[0] <= {fsync, dout, sck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_q     = sync_reg[SYNC_STAGES-1];
    assign rise       = sync_q & ~prev_reg;
    assign sck_rise   = rise[0];
    assign dout_s     = sync_q[1];
    assign fsync_rise = rise[2];
    assign last_bit   = (bitcnt_reg == BITCNT_W'(DATA_W - 1));

    // The completing bit is taken straight from the synchroniser so the frame is
    // available in the same cycle its last sck edge is seen.
    assign frame_data  = {shift_reg[DATA_W-2:0], dout_s};
    assign frame_valid = capture_en && armed_reg && !fsync_rise && sck_rise && last_bit;
    assign frame_trunc = capture_en && fsync_rise && (bitcnt_reg != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_reg  <= '0;
            bitcnt_reg <= '0;
            armed_reg  <= 1'b0;
        end else if (!capture_en) begin
            bitcnt_reg <= '0;
            armed_reg  <= 1'b0;
        end else if (fsync_rise) begin
            bitcnt_reg <= '0;
            armed_reg  <= 1'b1;
        end else if (armed_reg && sck_rise) begin
            shift_reg <= {shift_reg[DATA_W-2:0], dout_s};
            if (last_bit) begin
                bitcnt_reg <= '0;
                armed_reg  <= 1'b0;
            end else begin
                bitcnt_reg <= bitcnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ads127l01_acq_ctrl.sv
// ADS127L01 bring-up sequencer and sample publisher for the DATA/STATUS register pair.
// Define ACQ_AVG_EN to publish the floor-average of every 2**AVG_LOG2 frames instead of each frame.
module ads127l01_acq_ctrl
    import lpdaq_pkg::*;
#(
    parameter int DATA_W        = ADS_DATA_W,
    parameter int SYNC_STAGES   = 2,
    parameter int RST_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 1024,
    parameter int FSYNC_TIMEOUT = 65536,
    parameter int AVG_LOG2      = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    output logic        adc_reset_n,
    output logic        adc_start,
    input  logic        sck,
    input  logic        dout,
    input  logic        fsync,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic        data_ack,
    input  logic        clr_flags,
    output logic        overrun,
    output logic        frame_err,
    output logic        timeout,
    output logic [1:0]  state_o
);

    localparam int CNT_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > FSYNC_TIMEOUT) ? CNT_MAX_A : FSYNC_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    acq_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              timeout_evt;
    logic              capture_en;
    logic              frame_valid;
    logic [DATA_W-1:0] frame_data;
    logic              frame_trunc;
    logic              fsync_rise;
    logic              publish;
    logic [DATA_W-1:0] sample;

    // Capture stops in the same cycle enable drops so a frame ending then is not published.
    assign capture_en = (state_reg == RUN) && enable;

    ads127l01_frame_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame_rx (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .capture_en  (capture_en),
        .sck         (sck),
        .dout        (dout),
        .fsync       (fsync),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_trunc (frame_trunc),
        .fsync_rise  (fsync_rise)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            adc_reset_n <= 1'b0;
            adc_start   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            adc_reset_n <= (state_next == SETTLE) || (state_next == RUN);
            adc_start   <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        timeout_evt = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = RST;
                    cnt_next   = CNT_W'(RST_CYCLES - 1);
                end
                RST: begin
                    if (cnt_reg == '0) begin
                        state_next = SETTLE;
                        cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_next = RUN;
                        cnt_next   = CNT_W'(FSYNC_TIMEOUT - 1);
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                RUN: begin
                    if (fsync_rise) begin
                        cnt_next = CNT_W'(FSYNC_TIMEOUT - 1);
                    end else if (cnt_reg == '0) begin
                        timeout_evt = 1'b1;
                        state_next  = RST;
                        cnt_next    = CNT_W'(RST_CYCLES - 1);
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef ACQ_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_sum;
    logic [AVG_LOG2-1:0]     fcnt_reg;

    assign acc_sum = acc_reg + $signed({{AVG_LOG2{frame_data[DATA_W-1]}}, frame_data});
    assign publish = frame_valid && (fcnt_reg == '1);
    // Dropping the low AVG_LOG2 bits of a two's-complement sum is a floor divide.
    assign sample  = acc_sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_reg  <= '0;
            fcnt_reg <= '0;
        end else if (!capture_en || publish) begin
            acc_reg  <= '0;
            fcnt_reg <= '0;
        end else if (frame_valid) begin
            acc_reg  <= acc_sum;
            fcnt_reg <= fcnt_reg + 1'b1;
        end
    end
`else
    assign publish = frame_valid;
    assign sample  = frame_data;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_out   <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (publish) begin
                data_out   <= sign_extend(REG_W'(sample), DATA_W);
                data_ready <= 1'b1;
            end else if (data_ack) begin
                data_ready <= 1'b0;
            end

            if (publish && data_ready && !data_ack) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end

            if (frame_trunc) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end

            if (timeout_evt) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_ads127l01_acq_ctrl.sv
// Randomised bench for ads127l01_acq_ctrl: an ADC frame-sync model drives frames and a
// behavioural model of the register pair and sticky flags predicts every observed value.
module tb_ads127l01_acq_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        sck = 1'b0;
    logic        dout = 1'b0;
    logic        fsync = 1'b0;
    logic        data_ack = 1'b0;
    logic        clr_flags = 1'b0;
    logic        adc_reset_n;
    logic        adc_start;
    logic [31:0] data_out;
    logic        data_ready;
    logic        overrun;
    logic        frame_err;
    logic        timeout;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the PS-visible registers
    logic [31:0] m_data  = '0;
    logic        m_ready = 1'b0;
    logic        m_ovr   = 1'b0;
    logic        m_ferr  = 1'b0;
    logic        m_to    = 1'b0;
    int          m_sum   = 0;
    int          m_cnt   = 0;
    bit          partial_pending = 1'b0;

    ads127l01_acq_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .adc_reset_n (adc_reset_n),
        .adc_start   (adc_start),
        .sck         (sck),
        .dout        (dout),
        .fsync       (fsync),
        .data_out    (data_out),
        .data_ready  (data_ready),
        .data_ack    (data_ack),
        .clr_flags   (clr_flags),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .timeout     (timeout),
        .state_o     (state_o)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic model_frame(input logic [23:0] w, input bit ack_same);
        bit          pub;
        logic [31:0] val;
`ifdef ACQ_AVG_EN
        int q;
        m_sum += int'($signed(w));
        m_cnt++;
        pub = (m_cnt == 4);
        q   = m_sum / 4;
        if (m_sum < 0 && (m_sum % 4) != 0) q--;
        val = q;
        if (pub) begin
            m_sum = 0;
            m_cnt = 0;
        end
`else
        pub = 1'b1;
        val = int'($signed(w));
`endif
        if (pub) begin
            if (m_ready && !ack_same) m_ovr = 1'b1;
            m_data  = val;
            m_ready = 1'b1;
        end else if (ack_same) begin
            m_ready = 1'b0;
        end
    endtask

    task automatic model_leave_run();
        m_sum = 0;
        m_cnt = 0;
        partial_pending = 1'b0;
    endtask

    // One fsync pulse then nbits sck periods of 8 aclk; ack_same pulses data_ack on the publish cycle.
    task automatic send_frame(input logic [23:0] w, input int nbits, input bit ack_same, input bit chk_lat);
        if (partial_pending) m_ferr = 1'b1;
        fsync = 1'b1;
        wait_neg(4);
        fsync = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            dout = w[23-i];
            wait_neg(4);
            sck = 1'b1;
            if (i == 23) begin
                wait_neg(2);
                if (chk_lat) check("lat_before", 32'(data_ready), 32'(m_ready));
                if (ack_same) data_ack = 1'b1;
                wait_neg(1);
                data_ack = 1'b0;
                model_frame(w, ack_same);
                if (chk_lat) begin
                    check("lat_ready", 32'(data_ready), 32'(m_ready));
                    check("lat_data", data_out, m_data);
                end
                wait_neg(1);
            end else begin
                wait_neg(4);
            end
            sck = 1'b0;
        end
        partial_pending = (nbits > 0) && (nbits < 24);
        wait_neg(4);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        wait_neg(1);
        data_ack = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1;
        wait_neg(1);
        clr_flags = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_data"}, data_out, m_data);
        check({tag, "_ready"}, 32'(data_ready), 32'(m_ready));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_to"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic bring_up();
        int n;
        enable = 1'b1;
        n = 0;
        while (state_o != 2'd1 && n < 10) begin
            wait_neg(1);
            n++;
        end
        check("enter_rst", 32'(state_o), 32'd1);
        n = 0;
        while (adc_reset_n == 1'b0 && n < 200) begin
            wait_neg(1);
            n++;
        end
        check("rst_low_cycles", n, 32'd64);
        n = 0;
        while (adc_start == 1'b0 && n < 2000) begin
            wait_neg(1);
            n++;
        end
        check("settle_cycles", n, 32'd1024);
        check("run_state", 32'(state_o), 32'd3);
        $display("bring-up done: reset low 64, start after 1024");
    endtask

    initial begin
        int          n;
        logic [23:0] w;
        int          mode;

        wait_neg(3);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_adc_reset_n", 32'(adc_reset_n), 32'd0);
        check("rst_adc_start", 32'(adc_start), 32'd0);
        check_regs("rst");
        aresetn = 1'b1;
        wait_neg(2);
        check("idle_hold", 32'(state_o), 32'd0);

        bring_up();

`ifdef ACQ_AVG_EN
        send_frame(24'd4, 24, 1'b0, 1'b1);
        send_frame(24'd5, 24, 1'b0, 1'b1);
        send_frame(24'd6, 24, 1'b0, 1'b1);
        check("avg_no_pub", 32'(data_ready), 32'd0);
        send_frame(24'hFFFFFD, 24, 1'b0, 1'b1);
        check("avg_data", data_out, 32'd3);
        check("avg_ready", 32'(data_ready), 32'd1);
        $display("avg of 4,5,6,-3 -> %0d", $signed(data_out));
        ack_pulse();
`endif

        send_frame(24'h7FFFFF, 24, 1'b0, 1'b1);
        check_regs("pos_max");
        ack_pulse();
        send_frame(24'h800001, 24, 1'b0, 1'b1);
        check_regs("neg");
`ifndef ACQ_AVG_EN
        check("pos_neg_value", data_out, 32'hFF800001);
`endif
        ack_pulse();

        send_frame(24'h123456, 24, 1'b0, 1'b0);
        send_frame(24'h654321, 24, 1'b0, 1'b1);
        check_regs("ovr");
`ifndef ACQ_AVG_EN
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_data", data_out, 32'h00654321);
`endif
        clr_pulse();
        check_regs("ovr_clr");
        send_frame(24'hABCDEF, 24, 1'b1, 1'b1);
        check_regs("ack_same");
`ifndef ACQ_AVG_EN
        check("ack_same_ovr", 32'(overrun), 32'd0);
`endif

        send_frame(24'h3C3C3C, 10, 1'b0, 1'b0);
        send_frame(24'h0F0F0F, 24, 1'b0, 1'b1);
        check_regs("trunc");
        clr_pulse();

        for (int k = 0; k < 20; k++) begin
            w    = 24'($urandom);
            mode = $urandom_range(2);
            if ($urandom_range(5) == 0) begin
                n = $urandom_range(23, 1);
                send_frame(w, n, 1'b0, 1'b0);
            end else begin
                n = 24;
                send_frame(w, 24, mode == 1, 1'b1);
                if (mode == 2) ack_pulse();
            end
            if ($urandom_range(3) == 0) clr_pulse();
            check_regs("rand");
            $display("frame %0d: word=%h bits=%0d ack=%0d data_out=%h ready=%0b ovr=%0b ferr=%0b",
                     k, w, n, mode, data_out, data_ready, overrun, frame_err);
        end

        // Hold fsync low in RUN until the watchdog fires
        wait_neg(65000);
        check("to_not_yet", 32'(timeout), 32'(m_to));
        check("to_still_run", 32'(state_o), 32'd3);
        n = 0;
        while (timeout == 1'b0 && n < 1000) begin
            wait_neg(1);
            n++;
        end
        check("to_fired", 32'(timeout), 32'd1);
        check("to_state_rst", 32'(state_o), 32'd1);
        m_to = 1'b1;
        model_leave_run();
        check_regs("to");
        $display("timeout after %0d extra cycles", n);

        n = 0;
        while (adc_start == 1'b0 && n < 2000) begin
            wait_neg(1);
            n++;
        end
        check("rerun", 32'(state_o), 32'd3);

        // Drop enable mid-frame; the remaining bits must not publish anything
        send_frame(24'h5A5A5A, 12, 1'b0, 1'b0);
        enable = 1'b0;
        wait_neg(1);
        check("dis_state", 32'(state_o), 32'd0);
        check("dis_start", 32'(adc_start), 32'd0);
        check("dis_reset_n", 32'(adc_reset_n), 32'd0);
        model_leave_run();
        for (int i = 0; i < 12; i++) begin
            dout = 1'($urandom);
            wait_neg(4);
            sck = 1'b1;
            wait_neg(4);
            sck = 1'b0;
        end
        wait_neg(4);
        check_regs("dis");
        clr_pulse();
        check_regs("dis_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
